ex_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline. Sits directly downstream of the ALU control decoder and consumes its 3-bit alucontrol.
- Contains the ID/EX pipeline register, operand forwarding muxes, the ALU and the EX/MEM pipeline register.
- Accepts stall/flush from the hazard unit and exports E-stage fields back to it.

---
 rtl/ex_stage.sv | 175 +++++++++++++++++
 tb/tb_ex_stage.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS pipeline.
// Holds the ID/EX register, the A/B operand forwarding muxes, the ALU and
// the EX/MEM register. It exports the E-stage fields the hazard unit needs.
//
// Optional feature macro: EX_ILLEGAL_TRAP_EN
//   When defined, an extra output illegalm flags a live (non-bubble) op that
//   carried an illegal ALU code, and that op's register and memory writes
//   are suppressed in M.
//
// Pipeline control: there is no valid/ready handshake. A bubble is an
// all-zero bundle. stalle freezes ID/EX and sends a bubble into EX/MEM.
// flushe loads a bubble into ID/EX. reset clears both registers and has
// priority over everything else.
module ex_stage #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stalle,
  input  logic             flushe,
  input  logic             regwrited,
  input  logic             memtoregd,
  input  logic             memwrited,
  input  logic             alusrcd,
  input  logic             regdstd,
  input  logic [2:0]       alucontrold,
  input  logic [WIDTH-1:0] rd1d,
  input  logic [WIDTH-1:0] rd2d,
  input  logic [RADDR-1:0] rsd,
  input  logic [RADDR-1:0] rtd,
  input  logic [RADDR-1:0] rdd,
  input  logic [WIDTH-1:0] signimmd,
  input  logic [1:0]       forwardae,
  input  logic [1:0]       forwardbe,
  input  logic [WIDTH-1:0] resultw,
  output logic [RADDR-1:0] rse,
  output logic [RADDR-1:0] rte,
  output logic [RADDR-1:0] writerege,
  output logic             regwritee,
  output logic             memtorege,
  output logic             regwritem,
  output logic             memtoregm,
  output logic             memwritem,
  output logic [WIDTH-1:0] aluoutm,
  output logic [WIDTH-1:0] writedatam,
  output logic [RADDR-1:0] writeregm,
`ifdef EX_ILLEGAL_TRAP_EN
  output logic             illegalm,
`endif
  output logic             zerom
);

  // E-stage state that is not directly a port
  logic             memwritee;
  logic             alusrce;
  logic             regdste;
  logic [2:0]       alucontrole;
  logic [WIDTH-1:0] rd1e;
  logic [WIDTH-1:0] rd2e;
  logic [RADDR-1:0] rde;
  logic [WIDTH-1:0] signimme;

  // E-stage combinational results
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic [WIDTH-1:0] writedatae;
  logic [WIDTH-1:0] aluresult;
  logic             zeroe;

  // ID/EX register: reset > flush (bubble) > stall (hold) > load
  always_ff @(posedge clk) begin
    if (reset || flushe) begin
      regwritee   <= 1'b0;
      memtorege   <= 1'b0;
      memwritee   <= 1'b0;
      alusrce     <= 1'b0;
      regdste     <= 1'b0;
      alucontrole <= 3'b000;
      rd1e        <= '0;
      rd2e        <= '0;
      rse         <= '0;
      rte         <= '0;
      rde         <= '0;
      signimme    <= '0;
    end else if (!stalle) begin
      regwritee   <= regwrited;
      memtorege   <= memtoregd;
      memwritee   <= memwrited;
      alusrce     <= alusrcd;
      regdste     <= regdstd;
      alucontrole <= alucontrold;
      rd1e        <= rd1d;
      rd2e        <= rd2d;
      rse         <= rsd;
      rte         <= rtd;
      rde         <= rdd;
      signimme    <= signimmd;
    end
  end

  // Forwarding muxes; the aluoutm path uses the value held before the edge
  always_comb begin
    srca       = rd1e;
    writedatae = rd2e;
    case (forwardae)
      2'b01:   srca = resultw;
      2'b10:   srca = aluoutm;
      default: srca = rd1e;
    endcase
    case (forwardbe)
      2'b01:   writedatae = resultw;
      2'b10:   writedatae = aluoutm;
      default: writedatae = rd2e;
    endcase
    srcb      = alusrce ? signimme : writedatae;
    writerege = regdste ? rde : rte;
  end

  // ALU; SLT compares full signed operands, illegal codes give 0
  always_comb begin
    aluresult = '0;
    case (alucontrole)
      3'b010:  aluresult = srca + srcb;
      3'b110:  aluresult = srca - srcb;
      3'b000:  aluresult = srca & srcb;
      3'b001:  aluresult = srca | srcb;
      3'b111:  aluresult = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      default: aluresult = '0;
    endcase
    zeroe = (aluresult == '0);
  end

`ifdef EX_ILLEGAL_TRAP_EN
  logic illegale;

  // A live op with one of the unused ALU codes
  always_comb begin
    illegale = (regwritee | memwritee | memtorege) &&
               ((alucontrole == 3'b011) || (alucontrole == 3'b100) ||
                (alucontrole == 3'b101));
  end
`endif

  // EX/MEM register: reset > stall (bubble) > load
  always_ff @(posedge clk) begin
    if (reset || stalle) begin
      regwritem  <= 1'b0;
      memtoregm  <= 1'b0;
      memwritem  <= 1'b0;
      aluoutm    <= '0;
      writedatam <= '0;
      writeregm  <= '0;
      zerom      <= 1'b0;
`ifdef EX_ILLEGAL_TRAP_EN
      illegalm   <= 1'b0;
`endif
    end else begin
      memtoregm  <= memtorege;
      aluoutm    <= aluresult;
      writedatam <= writedatae;
      writeregm  <= writerege;
      zerom      <= zeroe;
`ifdef EX_ILLEGAL_TRAP_EN
      regwritem  <= regwritee & ~illegale;
      memwritem  <= memwritee & ~illegale;
      illegalm   <= illegale;
`else
      regwritem  <= regwritee;
      memwritem  <= memwritee;
`endif
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized and directed bench for ex_stage. Each driven
// cycle pushes the predicted post-edge outputs into exp_q; a monitor pops
// and compares one entry after every rising edge.
// Define EX_ILLEGAL_TRAP_EN to exercise the illegal-op trap build.
module tb_ex_stage;

  localparam int W = 91;

  typedef struct packed {
    logic        regwrite;
    logic        memtoreg;
    logic        memwrite;
    logic        alusrc;
    logic        regdst;
    logic [2:0]  aluctl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
  } dec_t;

`ifdef EX_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        stalle;
  logic        flushe;
  logic        regwrited, memtoregd, memwrited, alusrcd, regdstd;
  logic [2:0]  alucontrold;
  logic [31:0] rd1d, rd2d, signimmd, resultw;
  logic [4:0]  rsd, rtd, rdd;
  logic [1:0]  forwardae, forwardbe;
  logic [4:0]  rse, rte, writerege, writeregm;
  logic        regwritee, memtorege;
  logic        regwritem, memtoregm, memwritem, zerom;
  logic [31:0] aluoutm, writedatam;
  logic        illegal_obs;

  ex_stage #(.WIDTH(32), .RADDR(5)) dut (
    .clk(clk), .reset(reset), .stalle(stalle), .flushe(flushe),
    .regwrited(regwrited), .memtoregd(memtoregd), .memwrited(memwrited),
    .alusrcd(alusrcd), .regdstd(regdstd), .alucontrold(alucontrold),
    .rd1d(rd1d), .rd2d(rd2d), .rsd(rsd), .rtd(rtd), .rdd(rdd),
    .signimmd(signimmd), .forwardae(forwardae), .forwardbe(forwardbe),
    .resultw(resultw), .rse(rse), .rte(rte), .writerege(writerege),
    .regwritee(regwritee), .memtorege(memtorege), .regwritem(regwritem),
    .memtoregm(memtoregm), .memwritem(memwritem), .aluoutm(aluoutm),
    .writedatam(writedatam), .writeregm(writeregm),
`ifdef EX_ILLEGAL_TRAP_EN
    .illegalm(illegal_obs),
`endif
    .zerom(zerom)
  );

`ifndef EX_ILLEGAL_TRAP_EN
  assign illegal_obs = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // reference model state: contents of E and the ALU value held in M
  dec_t        mdl_e;
  logic [31:0] mdl_aluoutm;

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd2:    return a + b;
      3'd6:    return a - b;
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd7:    return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_v,
                                       input logic [31:0] wb_v, input logic [31:0] m_v);
    if (sel == 2'd1) return wb_v;
    if (sel == 2'd2) return m_v;
    return reg_v;
  endfunction

  function automatic logic [W-1:0] observed();
    return {illegal_obs, regwritem, memtoregm, memwritem, aluoutm, writedatam,
            writeregm, zerom, regwritee, memtorege, rse, rte, writerege};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic st, input logic fl, input dec_t d,
                      input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] rw);
    logic [31:0] a, wd, b, res, m_alu, m_wd;
    logic [4:0]  wreg, m_wreg;
    logic        ill, m_rw, m_mr, m_mw, m_z, m_ill;
    dec_t        ne;
    @(negedge clk);
    reset = r; stalle = st; flushe = fl;
    regwrited = d.regwrite; memtoregd = d.memtoreg; memwrited = d.memwrite;
    alusrcd = d.alusrc; regdstd = d.regdst; alucontrold = d.aluctl;
    rd1d = d.rd1; rd2d = d.rd2; rsd = d.rs; rtd = d.rt; rdd = d.rd;
    signimmd = d.imm; forwardae = fa; forwardbe = fb; resultw = rw;

    // what the op currently in E produces
    a    = pick(fa, mdl_e.rd1, rw, mdl_aluoutm);
    wd   = pick(fb, mdl_e.rd2, rw, mdl_aluoutm);
    b    = mdl_e.alusrc ? mdl_e.imm : wd;
    res  = ref_alu(mdl_e.aluctl, a, b);
    wreg = mdl_e.regdst ? mdl_e.rd : mdl_e.rt;
    ill  = TRAP && (mdl_e.regwrite || mdl_e.memwrite || mdl_e.memtoreg) &&
           (mdl_e.aluctl inside {3'd3, 3'd4, 3'd5});

    if (r || st) begin
      {m_rw, m_mr, m_mw, m_z, m_ill} = '0;
      m_alu = '0; m_wd = '0; m_wreg = '0;
    end else begin
      m_rw = mdl_e.regwrite && !ill;
      m_mw = mdl_e.memwrite && !ill;
      m_mr = mdl_e.memtoreg;
      m_ill = ill;
      m_alu = res; m_wd = wd; m_wreg = wreg;
      m_z = (res == 32'd0);
    end

    if (r || fl)  ne = '0;
    else if (st)  ne = mdl_e;
    else          ne = d;
    mdl_e = ne;
    mdl_aluoutm = m_alu;

    exp_q.push_back({m_ill, m_rw, m_mr, m_mw, m_alu, m_wd, m_wreg, m_z,
                     ne.regwrite, ne.memtoreg, ne.rs, ne.rt,
                     (ne.regdst ? ne.rd : ne.rt)});
    @(posedge clk);
  endtask

  function automatic dec_t mk(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    dec_t d;
    d = '0;
    d.regwrite = 1'b1;
    d.regdst = 1'b1;
    d.aluctl = op;
    d.rd1 = x; d.rd2 = y;
    d.rs = 5'd1; d.rt = 5'd2; d.rd = 5'd3;
    return d;
  endfunction

  // op in, one more cycle, then look at M
  task automatic run_op(input dec_t d);
    step(0, 0, 0, d, 2'd0, 2'd0, 32'd0);
    step(0, 0, 0, '0, 2'd0, 2'd0, 32'd0);
    #2;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] o;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = observed();
        n_checks++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL scoreboard t=%0t actual=%h expected=%h", $time, o, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    dec_t d;
    logic [1:0] fa, fb;
    mdl_e = '0;
    mdl_aluoutm = '0;
    {reset, stalle, flushe, regwrited, memtoregd, memwrited, alusrcd, regdstd} = '0;
    alucontrold = '0; rd1d = '0; rd2d = '0; signimmd = '0; resultw = '0;
    rsd = '0; rtd = '0; rdd = '0; forwardae = '0; forwardbe = '0;

    // reset with busy inputs
    d = mk(3'd2, 32'h1234, 32'h0f0f);
    d.memwrite = 1'b1;
    step(1, 0, 0, d, 2'd1, 2'd2, 32'hdead);
    step(1, 0, 0, d, 2'd1, 2'd2, 32'hdead);
    #2;
    chk("reset_aluoutm", aluoutm, 32'd0);
    chk("reset_ctrl", {29'd0, regwritem, memwritem, memtoregm}, 32'd0);
    chk("reset_e", {22'd0, regwritee, rse, rte}, 32'd0);

    run_op(mk(3'd2, 32'd5, 32'd7));
    chk("add_5_7", aluoutm, 32'd12);
    chk("add_regwrite", {31'd0, regwritem}, 32'd1);
    chk("add_zero", {31'd0, zerom}, 32'd0);

    run_op(mk(3'd2, 32'h0f, 32'hf0)); chk("add_ff", aluoutm, 32'hff);
    run_op(mk(3'd6, 32'h0f, 32'hf0)); chk("sub", aluoutm, 32'hffffff1f);
    run_op(mk(3'd0, 32'h0f, 32'hf0)); chk("and", aluoutm, 32'h0);
    run_op(mk(3'd1, 32'h0f, 32'hf0)); chk("or", aluoutm, 32'hff);
    run_op(mk(3'd7, 32'hffffffff, 32'd1)); chk("slt_neg", aluoutm, 32'd1);
    run_op(mk(3'd7, 32'h7fffffff, 32'h80000000)); chk("slt_ovf", aluoutm, 32'd0);
    run_op(mk(3'd6, 32'd5, 32'd5));
    chk("sub_zero_val", aluoutm, 32'd0);
    chk("sub_zero_flag", {31'd0, zerom}, 32'd1);

    // forward A from aluoutm (0x100)
    step(0, 0, 0, mk(3'd2, 32'h100, 32'h0), 2'd0, 2'd0, 32'd0);
    step(0, 0, 0, mk(3'd2, 32'h0, 32'h1), 2'd0, 2'd0, 32'd0);
    step(0, 0, 0, '0, 2'd2, 2'd0, 32'd0);
    #2; chk("fwd_a_mem", aluoutm, 32'h101);

    // forward B from resultw
    step(0, 0, 0, mk(3'd2, 32'h10, 32'h20), 2'd0, 2'd0, 32'd0);
    step(0, 0, 0, '0, 2'd0, 2'd1, 32'd3);
    #2;
    chk("fwd_b_wb", writedatam, 32'd3);
    chk("fwd_b_sum", aluoutm, 32'h13);

    // select 11 behaves as register value
    step(0, 0, 0, mk(3'd2, 32'h40, 32'h2), 2'd0, 2'd0, 32'd0);
    step(0, 0, 0, '0, 2'd3, 2'd3, 32'h999);
    #2; chk("fwd_11", aluoutm, 32'h42);

    // stall two cycles, then the held op completes
    step(0, 0, 0, mk(3'd2, 32'd1, 32'd2), 2'd0, 2'd0, 32'd0);
    step(0, 1, 0, mk(3'd6, 32'd9, 32'd9), 2'd0, 2'd0, 32'd0);
    #2; chk("stall1_bubble", {31'd0, regwritem}, 32'd0);
    step(0, 1, 0, mk(3'd6, 32'd9, 32'd9), 2'd0, 2'd0, 32'd0);
    #2; chk("stall2_bubble", {31'd0, regwritem}, 32'd0);
    step(0, 0, 0, '0, 2'd0, 2'd0, 32'd0);
    #2;
    chk("stall_release", aluoutm, 32'd3);
    chk("stall_release_rw", {31'd0, regwritem}, 32'd1);

    // flush
    d = mk(3'd2, 32'd4, 32'd4);
    d.memwrite = 1'b1;
    step(0, 0, 1, d, 2'd0, 2'd0, 32'd0);
    step(0, 0, 0, '0, 2'd0, 2'd0, 32'd0);
    #2; chk("flush_bubble", {29'd0, regwritem, memwritem, memtoregm}, 32'd0);

    // flush and stall together
    step(0, 0, 0, mk(3'd2, 32'd1, 32'd1), 2'd0, 2'd0, 32'd0);
    step(0, 1, 1, mk(3'd2, 32'd2, 32'd2), 2'd0, 2'd0, 32'd0);
    step(0, 0, 0, '0, 2'd0, 2'd0, 32'd0);

    // reset mid-pipe: none of the ops emerge
    step(0, 0, 0, mk(3'd2, 32'd1, 32'd1), 2'd0, 2'd0, 32'd0);
    step(0, 0, 0, mk(3'd2, 32'd2, 32'd2), 2'd0, 2'd0, 32'd0);
    step(1, 0, 0, mk(3'd2, 32'd3, 32'd3), 2'd0, 2'd0, 32'd0);
    #2; chk("midreset_m", {29'd0, regwritem, memwritem, memtoregm}, 32'd0);
    step(0, 0, 0, '0, 2'd0, 2'd0, 32'd0);
    #2; chk("midreset_after", {31'd0, regwritem}, 32'd0);

    // illegal code
    run_op(mk(3'd4, 32'd5, 32'd6));
    chk("illegal_alu", aluoutm, 32'd0);
    chk("illegal_rw", {31'd0, regwritem}, TRAP ? 32'd0 : 32'd1);
    chk("illegal_flag", {31'd0, illegal_obs}, TRAP ? 32'd1 : 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      d.regwrite = 1'($urandom_range(0, 1));
      d.memtoreg = 1'($urandom_range(0, 1));
      d.memwrite = 1'($urandom_range(0, 1));
      d.alusrc   = 1'($urandom_range(0, 1));
      d.regdst   = 1'($urandom_range(0, 1));
      d.aluctl   = 3'($urandom_range(0, 7));
      d.rd1      = ($urandom_range(0, 3) == 0) ? 32'h80000000 + $urandom_range(0, 3) : $urandom();
      d.rd2      = ($urandom_range(0, 3) == 0) ? d.rd1 : $urandom();
      d.rs       = 5'($urandom_range(0, 31));
      d.rt       = 5'($urandom_range(0, 31));
      d.rd       = 5'($urandom_range(0, 31));
      d.imm      = $urandom();
      fa = 2'($urandom_range(0, 3));
      fb = 2'($urandom_range(0, 3));
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0), d, fa, fb, $urandom());
    end

    step(0, 0, 0, '0, 2'd0, 2'd0, 32'd0);
    #5;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
